// File: rtl/v810_exc_seq.sv
// V810 exception/interrupt entry sequencer.
// Accepts one exception or maskable interrupt, saves PC/PSW, updates ECR
// and PSW through the sysreg write port, then redirects fetch to the handler.
module v810_exc_seq #(
   parameter logic [4:0] SR_EIPC  = 5'd0,
   parameter logic [4:0] SR_EIPSW = 5'd1,
   parameter logic [4:0] SR_FEPC  = 5'd2,
   parameter logic [4:0] SR_FEPSW = 5'd3,
   parameter logic [4:0] SR_ECR   = 5'd4,
   parameter logic [4:0] SR_PSW   = 5'd5
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        CE,
   input  logic        EXC_REQ,
   input  logic [15:0] EXC_CODE,
   input  logic [31:0] EXC_VEC,
   input  logic [31:0] EXC_PC,
   input  logic        INT_REQ,
   input  logic [3:0]  INT_LEVEL,
   input  logic [31:0] INT_PC,
   input  logic [31:0] PSW_IN,
   input  logic [31:0] ECR_IN,
   output logic [4:0]  WA,
   output logic [31:0] WD,
   output logic        WE,
   output logic        BUSY,
   output logic        EXC_ACK,
   output logic        INT_ACK,
   output logic        REDIR_VALID,
   output logic [31:0] REDIR_PC,
   output logic        HALTED
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SAVE_PC  = 3'd1,
      S_SAVE_PSW = 3'd2,
      S_SAVE_ECR = 3'd3,
      S_SET_PSW  = 3'd4,
      S_REDIRECT = 3'd5,
      S_FATAL    = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, psw_q, ecr_q, vec_q;
   logic [15:0] code_q;
   logic [3:0]  lvl_q;
   logic        int_q, dup_q;
   logic        take_exc, take_int;
   logic        int_ok;
   logic [31:0] psw_new;

   // Interrupt is unmasked only with ID/EP/NP clear and level at or above PSW.I
   assign int_ok = INT_REQ && !EXC_REQ && !PSW_IN[12] && !PSW_IN[14] && !PSW_IN[15]
                   && (INT_LEVEL >= PSW_IN[19:16]);

   // Handler-entry PSW: ID set, AE cleared, EP or NP raised, I bumped for interrupts
   always_comb begin
      psw_new     = psw_q;
      psw_new[12] = 1'b1;
      psw_new[13] = 1'b0;
      if (dup_q) psw_new[15] = 1'b1;
      else       psw_new[14] = 1'b1;
      if (int_q) psw_new[19:16] = (lvl_q == 4'hF) ? 4'hF : lvl_q + 4'd1;
   end

   // Next-state and output decode; RES forces every output low
   always_comb begin
      state_d     = state_q;
      WA          = '0;
      WD          = '0;
      WE          = 1'b0;
      BUSY        = 1'b0;
      EXC_ACK     = 1'b0;
      INT_ACK     = 1'b0;
      REDIR_VALID = 1'b0;
      REDIR_PC    = '0;
      HALTED      = 1'b0;
      take_exc    = 1'b0;
      take_int    = 1'b0;
      if (!RES) begin
         BUSY = (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (CE && EXC_REQ) begin
                  take_exc = 1'b1;
                  EXC_ACK  = 1'b1;
                  state_d  = PSW_IN[15] ? S_FATAL : S_SAVE_PC;
               end else if (CE && int_ok) begin
                  take_int = 1'b1;
                  INT_ACK  = 1'b1;
                  state_d  = S_SAVE_PC;
               end
            end
            S_SAVE_PC: begin
               WE = 1'b1;
               WA = dup_q ? SR_FEPC : SR_EIPC;
               WD = pc_q;
               if (CE) state_d = S_SAVE_PSW;
            end
            S_SAVE_PSW: begin
               WE = 1'b1;
               WA = dup_q ? SR_FEPSW : SR_EIPSW;
               WD = psw_q;
               if (CE) state_d = S_SAVE_ECR;
            end
            S_SAVE_ECR: begin
               WE = 1'b1;
               WA = SR_ECR;
               WD = dup_q ? {code_q, ecr_q[15:0]} : {ecr_q[31:16], code_q};
               if (CE) state_d = S_SET_PSW;
            end
            S_SET_PSW: begin
               WE = 1'b1;
               WA = SR_PSW;
               WD = psw_new;
               if (CE) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
               REDIR_VALID = 1'b1;
               REDIR_PC    = vec_q;
               if (CE) state_d = S_IDLE;
            end
            S_FATAL: begin
               HALTED = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State register and context latches, captured on the acceptance edge
   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         psw_q   <= '0;
         ecr_q   <= '0;
         vec_q   <= '0;
         code_q  <= '0;
         lvl_q   <= '0;
         int_q   <= 1'b0;
         dup_q   <= 1'b0;
      end else if (CE) begin
         state_q <= state_d;
         if (take_exc) begin
            pc_q   <= EXC_PC;
            psw_q  <= PSW_IN;
            ecr_q  <= ECR_IN;
            code_q <= EXC_CODE;
            vec_q  <= PSW_IN[14] ? 32'hFFFF_FFD0 : EXC_VEC;
            dup_q  <= PSW_IN[14];
            int_q  <= 1'b0;
            lvl_q  <= '0;
         end else if (take_int) begin
            pc_q   <= INT_PC;
            psw_q  <= PSW_IN;
            ecr_q  <= ECR_IN;
            code_q <= {8'hFE, INT_LEVEL, 4'h0};
            vec_q  <= {24'hFF_FFFE, INT_LEVEL, 4'h0};
            dup_q  <= 1'b0;
            int_q  <= 1'b1;
            lvl_q  <= INT_LEVEL;
         end
      end
   end

endmodule

// File: tb/tb_v810_exc_seq.sv
// Directed scoreboard bench for the V810 exception entry sequencer.
module tb_v810_exc_seq;

   logic        CLK = 1'b0;
   logic        RES, CE, EXC_REQ, INT_REQ;
   logic [15:0] EXC_CODE;
   logic [31:0] EXC_VEC, EXC_PC, INT_PC, PSW_IN, ECR_IN;
   logic [3:0]  INT_LEVEL;
   logic [4:0]  WA;
   logic [31:0] WD, REDIR_PC;
   logic        WE, BUSY, EXC_ACK, INT_ACK, REDIR_VALID, HALTED;

   v810_exc_seq dut (
      .CLK(CLK), .RES(RES), .CE(CE),
      .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .EXC_VEC(EXC_VEC), .EXC_PC(EXC_PC),
      .INT_REQ(INT_REQ), .INT_LEVEL(INT_LEVEL), .INT_PC(INT_PC),
      .PSW_IN(PSW_IN), .ECR_IN(ECR_IN),
      .WA(WA), .WD(WD), .WE(WE), .BUSY(BUSY),
      .EXC_ACK(EXC_ACK), .INT_ACK(INT_ACK),
      .REDIR_VALID(REDIR_VALID), .REDIR_PC(REDIR_PC), .HALTED(HALTED)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0]  wa;
      logic [31:0] wd;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] rq[$];
   int checks = 0, errors = 0;
   int cyc = 0, ack_cyc = 0, exc_acks = 0, int_acks = 0, redirs = 0;
   int e0, i0, r0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_w(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.wa = a;
      e.wd = d;
      wq.push_back(e);
   endtask

   // Compare one cycle of DUT activity against the scoreboard queues
   task automatic monitor(input int busy_exp);
      if (busy_exp >= 0) chk("busy", BUSY, busy_exp);
      if (CE) begin
         cyc++;
         chk("ack_exclusive", EXC_ACK & INT_ACK, 0);
         if (EXC_ACK) begin exc_acks++; ack_cyc = cyc; end
         if (INT_ACK) begin int_acks++; ack_cyc = cyc; end
         if (WE) begin
            if (wq.size() == 0) chk("we_unexpected", WE, 0);
            else begin
               wr_t e;
               e = wq.pop_front();
               chk("wa", WA, e.wa);
               chk("wd", WD, e.wd);
            end
         end
         if (REDIR_VALID) begin
            redirs++;
            if (rq.size() == 0) chk("redir_unexpected", REDIR_VALID, 0);
            else begin
               logic [31:0] r;
               r = rq.pop_front();
               chk("redir_pc", REDIR_PC, r);
               chk("latency", cyc - ack_cyc, 5);
            end
         end
      end
   endtask

   task automatic step(input int busy_exp);
      @(negedge CLK);
      monitor(busy_exp);
      @(posedge CLK);
      #1;
   endtask

   task automatic set_exc(input logic [15:0] c, input logic [31:0] v, input logic [31:0] pc);
      EXC_CODE = c;
      EXC_VEC  = v;
      EXC_PC   = pc;
      EXC_REQ  = 1'b1;
   endtask

   // Acceptance cycle, five busy cycles, one idle cycle
   task automatic run_seq();
      step(0);
      EXC_REQ = 1'b0;
      INT_REQ = 1'b0;
      repeat (5) step(1);
      step(0);
   endtask

   task automatic snap();
      e0 = exc_acks;
      i0 = int_acks;
      r0 = redirs;
   endtask

   task automatic end_chk(input string tag, input int de, input int di, input int dr);
      chk({tag, "_exc_acks"}, exc_acks - e0, de);
      chk({tag, "_int_acks"}, int_acks - i0, di);
      chk({tag, "_redirs"}, redirs - r0, dr);
      chk({tag, "_wq_left"}, wq.size(), 0);
      chk({tag, "_rq_left"}, rq.size(), 0);
   endtask

   initial begin
      RES = 1'b1; CE = 1'b1; EXC_REQ = 1'b0; INT_REQ = 1'b0;
      EXC_CODE = '0; EXC_VEC = '0; EXC_PC = '0; INT_PC = '0;
      INT_LEVEL = '0; PSW_IN = '0; ECR_IN = '0;
      step(-1);
      step(-1);
      RES = 1'b0;
      @(negedge CLK);
      chk("rst_wa", WA, 0);
      chk("rst_wd", WD, 0);
      chk("rst_we", WE, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_redir", {REDIR_VALID, REDIR_PC}, 0);
      chk("rst_halt_ack", {HALTED, EXC_ACK, INT_ACK}, 0);
      @(posedge CLK);
      #1;

      // Normal TRAP
      snap();
      PSW_IN = 32'h0000_0000; ECR_IN = 32'h1234_5678;
      push_w(5'd0, 32'h0000_1004); push_w(5'd1, 32'h0000_0000);
      push_w(5'd4, 32'h1234_FFA5); push_w(5'd5, 32'h0000_5000);
      rq.push_back(32'hFFFF_FFA0);
      set_exc(16'hFFA5, 32'hFFFF_FFA0, 32'h0000_1004);
      run_seq();
      end_chk("trap", 1, 0, 1);

      // Duplexed exception
      snap();
      PSW_IN = 32'h0000_4000; ECR_IN = 32'h0000_FE30;
      push_w(5'd2, 32'h0000_2000); push_w(5'd3, 32'h0000_4000);
      push_w(5'd4, 32'hFF90_FE30); push_w(5'd5, 32'h0000_D000);
      rq.push_back(32'hFFFF_FFD0);
      set_exc(16'hFF90, 32'hFFFF_FFA0, 32'h0000_2000);
      run_seq();
      end_chk("dup", 1, 0, 1);

      // Interrupt masked by level, then by ID
      snap();
      PSW_IN = 32'h0004_0000; INT_LEVEL = 4'd3; INT_REQ = 1'b1;
      repeat (3) step(0);
      PSW_IN = 32'h0000_1000; INT_LEVEL = 4'd15;
      repeat (2) step(0);
      INT_REQ = 1'b0;
      end_chk("mask", 0, 0, 0);

      // Interrupt level 3 accepted with PSW.I=2
      snap();
      PSW_IN = 32'h0002_0000; ECR_IN = 32'h0000_0000; INT_LEVEL = 4'd3; INT_PC = 32'h0000_3000;
      push_w(5'd0, 32'h0000_3000); push_w(5'd1, 32'h0002_0000);
      push_w(5'd4, 32'h0000_FE30); push_w(5'd5, 32'h0004_5000);
      rq.push_back(32'hFFFF_FE30);
      INT_REQ = 1'b1;
      run_seq();
      end_chk("int3", 0, 1, 1);

      // Interrupt level 15 saturates I at 15
      snap();
      PSW_IN = 32'h0000_0000; ECR_IN = 32'hAAAA_5555; INT_LEVEL = 4'd15; INT_PC = 32'h0000_3100;
      push_w(5'd0, 32'h0000_3100); push_w(5'd1, 32'h0000_0000);
      push_w(5'd4, 32'hAAAA_FEF0); push_w(5'd5, 32'h000F_5000);
      rq.push_back(32'hFFFF_FEF0);
      INT_REQ = 1'b1;
      run_seq();
      end_chk("int15", 0, 1, 1);

      // Collision: exception wins, held interrupt not retaken once ID is set
      snap();
      PSW_IN = 32'h0000_0000; ECR_IN = 32'h0000_0000; INT_LEVEL = 4'd5;
      push_w(5'd0, 32'h0000_4000); push_w(5'd1, 32'h0000_0000);
      push_w(5'd4, 32'h0000_FFA0); push_w(5'd5, 32'h0000_5000);
      rq.push_back(32'hFFFF_FFA0);
      set_exc(16'hFFA0, 32'hFFFF_FFA0, 32'h0000_4000);
      INT_REQ = 1'b1;
      step(0);
      EXC_REQ = 1'b0;
      repeat (5) step(1);
      PSW_IN = 32'h0000_5000;
      repeat (3) step(0);
      INT_REQ = 1'b0;
      end_chk("coll", 1, 0, 1);

      // CE held low for three cycles inside SAVE_ECR
      snap();
      PSW_IN = 32'h0000_0000; ECR_IN = 32'h0000_0000;
      push_w(5'd0, 32'h0000_5000); push_w(5'd1, 32'h0000_0000);
      push_w(5'd4, 32'h0000_FFA1); push_w(5'd5, 32'h0000_5000);
      rq.push_back(32'hFFFF_FFA0);
      set_exc(16'hFFA1, 32'hFFFF_FFA0, 32'h0000_5000);
      step(0);
      EXC_REQ = 1'b0;
      step(1);
      step(1);
      CE = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         chk("frz_wa", WA, 5'd4);
         chk("frz_wd", WD, 32'h0000_FFA1);
         chk("frz_busy_we", {BUSY, WE}, 2'b11);
         @(posedge CLK);
         #1;
      end
      CE = 1'b1;
      repeat (3) step(1);
      step(0);
      end_chk("ce", 1, 0, 1);

      // Reset pulsed in SET_PSW aborts the sequence
      snap();
      push_w(5'd0, 32'h0000_6000); push_w(5'd1, 32'h0000_0000);
      push_w(5'd4, 32'h0000_FFA2);
      set_exc(16'hFFA2, 32'hFFFF_FFA0, 32'h0000_6000);
      step(0);
      EXC_REQ = 1'b0;
      repeat (3) step(1);
      RES = 1'b1;
      step(0);
      RES = 1'b0;
      repeat (3) step(0);
      end_chk("rstmid", 1, 0, 0);

      // Fatal: NP set, no writes, halted until reset
      snap();
      PSW_IN = 32'h0000_8000;
      set_exc(16'hFFA3, 32'hFFFF_FFA0, 32'h0000_7000);
      step(0);
      EXC_REQ = 1'b0;
      repeat (4) step(1);
      @(negedge CLK);
      chk("fatal_halted", HALTED, 1);
      @(posedge CLK);
      #1;
      RES = 1'b1;
      step(0);
      RES = 1'b0;
      PSW_IN = 32'h0000_0000;
      @(negedge CLK);
      chk("fatal_cleared", {HALTED, BUSY}, 2'b00);
      @(posedge CLK);
      #1;
      end_chk("fatal", 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
